memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Shares the single external 16-bit SRAM between instruction fetch (read-only) and the memory-access stage (read/write).
- Sits between the CPU's IF/MEM ports and the board SRAM.
- Runs multi-cycle SRAM accesses and drives a pipeline stall while any request is outstanding.
- Arbitration: round-robin when both requesters contend; otherwise the single requester is granted.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- ACCESS_CYCLES, 2, cycles the SRAM strobes stay active per access; legal range 1..15.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request, level, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction word, registered.
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- mem_ctrl  in  2  00 idle, 01 read, 10 write, 11 reserved (treated as 00).
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load result, registered.
- mem_ready  out  1  one-cycle pulse: load/store complete.
- stall  out  1  combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready), where mem_req = mem_ctrl is 01 or 10.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data; separate from the read bus, no tri-state inside this block.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE; timer 0; last_grant = MEM, so IF wins the first tie.
  - if_ready and mem_ready 0; if_rdata and mem_rdata 0.
  - sram_ce_n, sram_oe_n and sram_we_n all 1; sram_addr and sram_wdata 0.
  - Reset mid-access aborts immediately; strobes deassert asynchronously and no ready pulse is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - On grant: latch owner, address, write data and direction; load timer = ACCESS_CYCLES-1; go to ACCESS.
  - Input changes after grant are ignored until DONE.
- ACCESS:
  - sram_ce_n = 0.
  - Read: sram_oe_n = 0, sram_we_n = 1.
  - Write: sram_oe_n = 1, sram_we_n = 0.
  - sram_addr and sram_wdata hold the latched values.
  - Timer decrements each cycle. At timer 0: for a read, capture sram_rdata into the owner's rdata register; go to DONE.
- DONE (1 cycle):
  - All strobes 1; sram_addr and sram_wdata still held, giving address/data hold after sram_we_n rises.
  - Owner's ready = 1; last_grant = owner; go to IDLE.
- Latency:
  - Request seen in IDLE at edge k → ready high in cycle k+ACCESS_CYCLES+1.
  - Minimum spacing between accesses is ACCESS_CYCLES+2 cycles.
- Back-to-back: a requester keeping req high after its ready pulse is treated as a new request in the following IDLE cycle. Requesters must drop req in the cycle ready is high unless a new access is intended.
- rdata registers hold their value until that port's next completed read. mem_rdata is unchanged by writes.
- Non-owner ready is always 0. if_ready and mem_ready are never high in the same cycle.
- Reserved mem_ctrl = 11 produces no access and no stall contribution.

Decomposition:
- Shared package (memory_port_pkg):
  - mem_ctrl encodings: MEM_IDLE, MEM_READ, MEM_WRITE, MEM_RSVD.
  - FSM state encodings: IDLE, ACCESS, DONE.
  - Owner encoding: OWNER_IF, OWNER_MEM.
  - ACCESS_CYCLES default.
- One sub-module, sram_access_timer: loadable down-counter with a terminal-count flag, asynchronous active-low reset.

Test Plan:
- Reset: hold reset low 3 cycles with if_req = 1 → all strobes 1, readies 0, rdata 0; first grant occurs 1 cycle after reset releases.
- IF read: if_addr = 0x0040, sram_rdata = 0x1234, ACCESS_CYCLES = 2 → sram_oe_n low for exactly 2 cycles, if_ready pulses 3 cycles after the request edge, if_rdata = 0x1234; stall high until that cycle.
- Write: mem_ctrl = 10, mem_addr = 0x8000, mem_wdata = 0xBEEF → sram_we_n low for 2 cycles at addr 0x8000 / data 0xBEEF, addr/data still held in the DONE cycle, mem_ready pulses once, mem_rdata unchanged.
- Contention: if_req and mem_ctrl = 01 asserted together right after reset → IF served first, then MEM, then IF again. Grants alternate while both are held; readies are never coincident.
- Abort: reset driven low in the 2nd ACCESS cycle of a write → sram_we_n rises within the same cycle (asynchronously), no mem_ready; after release, a re-issued request completes normally.
- Reserved/ignore: mem_ctrl = 11 → no SRAM activity and stall = 0. Changing if_addr mid-ACCESS → sram_addr keeps the latched value.

Source files
------------

// File: rtl/memory_port_pkg.sv
// memory_port_pkg
//    Shared encodings for the instruction-fetch / memory-stage SRAM arbiter:
//    memory-stage command codes, arbiter FSM states, port-owner codes and the
//    default SRAM access length.
package memory_port_pkg;

   // Memory-stage command on mem_ctrl; MEM_RSVD behaves exactly like MEM_IDLE.
   typedef enum logic [1:0] {
      MEM_IDLE  = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10,
      MEM_RSVD  = 2'b11
   } memCtrlT;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } arbStateT;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } ownerT;

   // Cycles the SRAM strobes stay active per access (legal range 1..15).
   localparam int ACCESS_CYCLES_DEFAULT = 2;

   // Timer width covers the largest legal load value (15 - 1).
   localparam int TIMER_W = 4;

endpackage

// File: rtl/sram_access_timer.sv
// sram_access_timer
//    Loadable down-counter that paces one SRAM access. The count stops at
//    zero, and terminal is high whenever the count is zero.
// Ports:
//    clock      in  system clock
//    reset      in  asynchronous active-low reset (count clears to 0)
//    load       in  load loadValue this cycle (has priority over decrement)
//    loadValue  in  value to load
//    decrement  in  count down by one this cycle (saturates at 0)
//    terminal   out count is zero
module sram_access_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   input  logic             decrement,
   output logic             terminal
);

   logic [WIDTH-1:0] countReg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         countReg <= '0;
      end else if (load) begin
         countReg <= loadValue;
      end else if (decrement && (countReg != '0)) begin
         countReg <= countReg - 1'b1;
      end
   end

   assign terminal = (countReg == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//    Shares one external asynchronous SRAM between instruction fetch
//    (read-only) and the memory-access stage (read/write). Each access runs
//    IDLE -> ACCESS (ACCESS_CYCLES cycles with strobes active) -> DONE (one
//    cycle: strobes released, address/data still held, ready pulse).
//    Contention is resolved round-robin against the last completed owner.
// Ports:
//    clock, reset               clock, asynchronous active-low reset
//    if_req/if_addr             fetch read request (level) and address
//    if_rdata/if_ready          registered fetch data, one-cycle done pulse
//    mem_ctrl/mem_addr/mem_wdata memory-stage command, address, store data
//    mem_rdata/mem_ready        registered load data, one-cycle done pulse
//    stall                      pipeline stall while any request is open
//    sram_addr/sram_wdata       SRAM address and write data (registered)
//    sram_rdata                 SRAM read data
//    sram_ce_n/oe_n/we_n        active-low SRAM strobes (registered)
module memory_port_arbiter
   import memory_port_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic [1:0]        mem_ctrl,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ACCESS_CYCLES - 1);

   arbStateT stateReg;
   ownerT    ownerReg;
   ownerT    lastGrantReg;
   logic     writeReg;

   logic memReq;
   logic memWrite;
   logic grantIf;
   logic grantMem;
   logic timerDone;

   // The reserved code is neither a request nor a stall source.
   assign memReq   = (mem_ctrl == MEM_READ) || (mem_ctrl == MEM_WRITE);
   assign memWrite = (mem_ctrl == MEM_WRITE);

   assign stall = (if_req & ~if_ready) | (memReq & ~mem_ready);

   // Requests are only looked at in IDLE; on a tie the port that did not
   // own the previous access wins.
   always_comb begin
      grantIf  = 1'b0;
      grantMem = 1'b0;
      if (stateReg == IDLE) begin
         if (if_req && memReq) begin
            if (lastGrantReg == OWNER_MEM) grantIf  = 1'b1;
            else                           grantMem = 1'b1;
         end else if (if_req) begin
            grantIf = 1'b1;
         end else if (memReq) begin
            grantMem = 1'b1;
         end
      end
   end

   sram_access_timer #(
      .WIDTH(TIMER_W)
   ) accessTimer (
      .clock     (clock),
      .reset     (reset),
      .load      (grantIf | grantMem),
      .loadValue (TIMER_LOAD),
      .decrement (stateReg == ACCESS),
      .terminal  (timerDone)
   );

   // Strobes are set on the grant edge so they are active for exactly the
   // ACCESS cycles; read data is captured on the last ACCESS edge while
   // sram_oe_n is still low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg     <= IDLE;
         ownerReg     <= OWNER_IF;
         lastGrantReg <= OWNER_MEM;
         writeReg     <= 1'b0;
         if_rdata     <= '0;
         if_ready     <= 1'b0;
         mem_rdata    <= '0;
         mem_ready    <= 1'b0;
         sram_addr    <= '0;
         sram_wdata   <= '0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
      end else begin
         case (stateReg)
            IDLE: begin
               if (grantIf) begin
                  ownerReg  <= OWNER_IF;
                  writeReg  <= 1'b0;
                  sram_addr <= if_addr;
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
                  sram_we_n <= 1'b1;
                  stateReg  <= ACCESS;
               end else if (grantMem) begin
                  ownerReg   <= OWNER_MEM;
                  writeReg   <= memWrite;
                  sram_addr  <= mem_addr;
                  sram_wdata <= mem_wdata;
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= memWrite;
                  sram_we_n  <= ~memWrite;
                  stateReg   <= ACCESS;
               end
            end
            ACCESS: begin
               if (timerDone) begin
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  if (ownerReg == OWNER_IF) begin
                     if_rdata <= sram_rdata;
                     if_ready <= 1'b1;
                  end else begin
                     if (!writeReg) mem_rdata <= sram_rdata;
                     mem_ready <= 1'b1;
                  end
                  stateReg <= DONE;
               end
            end
            DONE: begin
               if_ready     <= 1'b0;
               mem_ready    <= 1'b0;
               lastGrantReg <= ownerReg;
               stateReg     <= IDLE;
            end
            default: begin
               stateReg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter
//    Self-checking bench: a small SRAM model on the pins, a table of single
//    accesses, a scoreboard of expected completions (owner, data, cycle) and
//    directed sequences for reset, abort, reserved command and contention.
module tb_memory_port_arbiter;

   localparam int AC = 2;

   typedef struct {
      bit          isIf;
      logic [15:0] rdata;
      int          cycle;
   } expT;

   typedef struct {
      bit          isIf;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] expRd;
   } vecT;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_ready;
   logic [1:0]  mem_ctrl;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   logic [15:0] sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  txn   = 0;
   expT expQ[$];
   vecT vecs[10];

   // SRAM model: 256 words addressed by a fold of the address; unwritten
   // words return a fixed pattern, and the bus reads garbage unless enabled.
   logic [15:0] sramMem [0:255];
   logic        sramWritten [0:255];
   logic [7:0]  sramIdx;

   assign sramIdx = sram_addr[15:8] ^ sram_addr[7:0];

   always_comb begin
      sram_rdata = 16'hDEAD;
      if (!sram_ce_n && !sram_oe_n) begin
         if (sramWritten[sramIdx]) sram_rdata = sramMem[sramIdx];
         else if (sram_addr == 16'h0040) sram_rdata = 16'h1234;
         else sram_rdata = {8'hC0, sramIdx};
      end
   end

   always @(posedge clock) begin
      if (!sram_ce_n && !sram_we_n) begin
         sramMem[sramIdx]     <= sram_wdata;
         sramWritten[sramIdx] <= 1'b1;
      end
   end

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   memory_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(AC)
   ) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pops one expectation per ready pulse and checks owner, cycle and data.
   task automatic monitorLoop();
      expT e;
      forever begin
         @(posedge clock);
         #1;
         if (if_ready || mem_ready) begin
            if (expQ.size() == 0) begin
               check("unexpected_ready", {30'd0, if_ready, mem_ready}, 32'd0);
            end else begin
               e = expQ.pop_front();
               txn++;
               check("ready_owner", {30'd0, if_ready, mem_ready}, e.isIf ? 32'd2 : 32'd1);
               check("ready_cycle", cyc, e.cycle);
               if (e.isIf) check("if_rdata", if_rdata, e.rdata);
               else        check("mem_rdata", mem_rdata, e.rdata);
               $display("txn %0d: port=%s if_rdata=%h mem_rdata=%h cycle=%0d",
                        txn, e.isIf ? "IF" : "MEM", if_rdata, mem_rdata, cyc);
            end
         end
      end
   endtask

   // Called at a negedge; the request is sampled on the next rising edge.
   task automatic startReq(bit isIf, bit wr, logic [15:0] addr,
                           logic [15:0] wdata, logic [15:0] expRd);
      expT e;
      if (isIf) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         mem_ctrl  = wr ? 2'b10 : 2'b01;
         mem_addr  = addr;
         mem_wdata = wdata;
      end
      e.isIf  = isIf;
      e.rdata = expRd;
      e.cycle = cyc + 1 + AC;
      expQ.push_back(e);
   endtask

   // Watches one single-requester access to completion, scrambling the
   // requester's address/data after the grant to confirm they are latched.
   task automatic waitDone(bit isIf, bit wr, logic [15:0] addr, logic [15:0] wdata);
      int oeCnt   = 0;
      int weCnt   = 0;
      bit busOk   = 1'b1;
      bit stallOk = 1'b1;
      bit done    = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clock);
         if (isIf ? if_ready : mem_ready) begin
            done = 1'b1;
            check("done_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
            check("done_addr_hold", sram_addr, addr);
            if (wr) check("done_wdata_hold", sram_wdata, wdata);
            check("done_stall", stall, 1'b0);
            if (isIf) if_req = 1'b0;
            else      mem_ctrl = 2'b00;
         end else begin
            if (!sram_oe_n) oeCnt++;
            if (!sram_we_n) weCnt++;
            if (!sram_ce_n && sram_addr !== addr) busOk = 1'b0;
            if (!sram_we_n && sram_wdata !== wdata) busOk = 1'b0;
            if (!stall) stallOk = 1'b0;
            if (isIf) begin
               if_addr = 16'($urandom);
            end else begin
               mem_addr  = 16'($urandom);
               mem_wdata = 16'($urandom);
            end
         end
      end
      check("access_timeout", done, 1'b1);
      check("oe_low_cycles", oeCnt, wr ? 0 : AC);
      check("we_low_cycles", weCnt, wr ? AC : 0);
      check("bus_latched", busOk, 1'b1);
      check("stall_while_busy", stallOk, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int ifCnt;
      int memCnt;

      for (int i = 0; i < 256; i++) sramWritten[i] = 1'b0;
      // isIf, wr, addr, wdata, expected rdata (for writes: mem_rdata unchanged)
      vecs[0] = '{1'b0, 1'b1, 16'h8000, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'hBEEF};
      vecs[3] = '{1'b0, 1'b1, 16'h0123, 16'h0F0F, 16'hBEEF};
      vecs[4] = '{1'b0, 1'b0, 16'h0123, 16'h0000, 16'h0F0F};
      vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234};
      vecs[6] = '{1'b0, 1'b1, 16'h0040, 16'hCAFE, 16'h0F0F};
      vecs[7] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hCAFE};
      vecs[8] = '{1'b0, 1'b0, 16'h7F00, 16'h0000, 16'hC07F};
      vecs[9] = '{1'b1, 1'b0, 16'h0123, 16'h0000, 16'h0F0F};

      reset     = 1'b0;
      if_req    = 1'b1;
      if_addr   = 16'h0040;
      mem_ctrl  = 2'b00;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      fork
         monitorLoop();
      join_none

      // Reset held with a pending fetch: everything quiet.
      repeat (3) @(negedge clock);
      check("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
      check("rst_readies", {30'd0, if_ready, mem_ready}, 32'd0);
      check("rst_if_rdata", if_rdata, 16'h0000);
      check("rst_mem_rdata", mem_rdata, 16'h0000);
      check("rst_sram_addr", sram_addr, 16'h0000);

      // Release: the held fetch is granted on the very next edge.
      reset = 1'b1;
      startReq(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234);
      @(posedge clock);
      #1;
      check("first_grant", {30'd0, sram_ce_n, sram_oe_n}, 32'd0);
      waitDone(1'b1, 1'b0, 16'h0040, 16'h0000);

      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         startReq(vecs[i].isIf, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expRd);
         waitDone(vecs[i].isIf, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      end

      // Reserved command: no access and no stall.
      @(negedge clock);
      mem_ctrl = 2'b11;
      ok = 1'b1;
      repeat (6) begin
         @(negedge clock);
         if (stall || !sram_ce_n || !sram_oe_n || !sram_we_n) ok = 1'b0;
      end
      check("rsvd_quiet", ok, 1'b1);
      check("rsvd_stall", stall, 1'b0);
      mem_ctrl = 2'b00;

      // Abort a write in its second ACCESS cycle.
      @(negedge clock);
      mem_ctrl  = 2'b10;
      mem_addr  = 16'h0200;
      mem_wdata = 16'h1111;
      @(posedge clock);
      @(posedge clock);
      #2;
      check("abort_pre_we", {30'd0, sram_ce_n, sram_we_n}, 32'd0);
      reset = 1'b0;
      #1;
      check("abort_we_async", {30'd0, sram_ce_n, sram_we_n}, 32'd3);
      mem_ctrl = 2'b00;
      repeat (3) @(negedge clock);
      check("abort_no_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      startReq(1'b0, 1'b1, 16'h0200, 16'h1111, 16'h0000);
      waitDone(1'b0, 1'b1, 16'h0200, 16'h1111);
      @(negedge clock);
      startReq(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1111);
      waitDone(1'b0, 1'b0, 16'h0200, 16'h0000);

      // Contention straight after reset: IF, MEM, IF, MEM.
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset     = 1'b1;
      if_req    = 1'b1;
      if_addr   = 16'h0040;
      mem_ctrl  = 2'b01;
      mem_addr  = 16'h8000;
      expQ.push_back('{1'b1, 16'hCAFE, cyc + 1 + AC});
      expQ.push_back('{1'b0, 16'hBEEF, cyc + 1 + 2*AC + 2});
      expQ.push_back('{1'b1, 16'hCAFE, cyc + 1 + 3*AC + 4});
      expQ.push_back('{1'b0, 16'hBEEF, cyc + 1 + 4*AC + 6});
      ifCnt  = 0;
      memCnt = 0;
      for (int i = 0; i < 100 && (ifCnt < 2 || memCnt < 2); i++) begin
         @(negedge clock);
         if (if_ready) begin
            ifCnt++;
            if (ifCnt == 2) if_req = 1'b0;
         end
         if (mem_ready) begin
            memCnt++;
            if (memCnt == 2) mem_ctrl = 2'b00;
         end
      end
      check("contention_if_count", ifCnt, 2);
      check("contention_mem_count", memCnt, 2);
      if_req   = 1'b0;
      mem_ctrl = 2'b00;

      repeat (5) @(negedge clock);
      check("scoreboard_drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
